fetch_queue_if: RTL
===================

# fetch_queue_if

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue. It replaces the single IF/ID register with a FIFO, and its head entry is the IF/ID register contents that ID decodes. It drives the instruction memory with a word address and redirects on branch/jump from ID. Delay-slot semantics are selectable, and bad fetch addresses are flagged with an address-error bit.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- IM_BASE, 32'h0000_3000, byte address of IM word 0
- IM_WORDS, 1024, IM size in words; AW = $clog2(IM_WORDS)
- DEPTH, 4, queue entries; power of two, ≥2
- DELAY_SLOT, 1, 1 = MIPS branch delay slot kept; 0 = no delay slot

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- branch  input  1  redirect request from ID, target branch_addr32
- branch_addr32  input  32  branch target
- jump  input  1  redirect request from ID, target jump_addr32; jump wins if branch is also high
- jump_addr32  input  32  jump target
- Stall  input  1  ID holds its current instruction; head is not popped
- im_addr  output  AW  combinational word address into IM: (fetch_pc − IM_BASE) >> 2
- im_instr  input  32  combinational IM read data for im_addr
- valid  output  1  head entry present
- Instr  output  32  head instruction; 32'h0 when !valid
- PC  output  32  head PC; 0 when !valid
- PC_4  output  32  head PC + 4; 0 when !valid
- exc_adel  output  1  head entry had a fetch address error; 0 when !valid
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry: {pc[31:0], instr[31:0], err}.
- pop = valid & !Stall.
- push = !redirect_flush_case & (count < DEPTH | pop).
  - Push writes {fetch_pc, err ? 0 : im_instr, err}.
  - On push, fetch_pc advances by 4 (mod 2^32).
- err = (fetch_pc[1:0] != 0) | fetch_pc < IM_BASE | fetch_pc ≥ IM_BASE + 4·IM_WORDS.
  - Fetching continues after an err entry.
- redirect = (jump | branch) & valid & !Stall.
  - It applies to the head, i.e. the branch/jump in ID.
  - Redirect while Stall=1 or !valid is ignored.
  - target = jump ? jump_addr32 : branch_addr32.
- Redirect, DELAY_SLOT=1: head popped; the next entry (the delay slot) is retained if present; all younger entries are discarded.
  - If the delay slot is not yet queued, this cycle's push (from fetch_pc = branch PC + 4) proceeds.
  - fetch_pc <= target.
- Redirect, DELAY_SLOT=0: the queue is emptied, there is no push this cycle, and fetch_pc <= target.
- Full (count == DEPTH) with no pop: no push, fetch_pc and im_addr hold.
- Full with pop: push and pop in the same cycle; count unchanged.
- Empty: valid=0 and outputs are the bubble values (Instr=0 is a MIPS nop); Stall has no effect.
- Pointer arithmetic is modulo DEPTH; count ranges from 0 to DEPTH, inclusive.

## Timing
- Reset (asynchronous) takes effect without a clock edge:
  - count = 0, valid = 0
  - Instr = PC = PC_4 = 0, exc_adel = 0
  - fetch_pc = RESET_PC
- First posedge after reset deasserts: RESET_PC is pushed, and valid=1 from that edge.
- Latency fetch_pc → head is 1 cycle when the queue is empty.
- Throughput: one instruction per cycle while Stall=0.
- Redirect, DELAY_SLOT=1, delay slot queued:
  - Delay slot is head on the next cycle.
  - target is head two cycles after the redirect edge, at the earliest.
- Redirect, DELAY_SLOT=0: one bubble cycle (valid=0), then target is head.
- Reset asserted mid-fetch or mid-redirect discards everything; no partial state survives.
- Outputs are registered or derived from queue storage only. No combinational path from Stall, branch or jump to Instr, PC or valid.

## Test plan
- Async reset: during a run with count=3, raise reset between clock edges → valid=0, Instr=0, PC=0, count=0 before the next posedge. Release → PCs 0x3000, 0x3004, 0x3008 appear one per cycle.
- Backpressure, DEPTH=4: Stall=1 for 6 cycles after the first fetch.
  - count saturates at 4, and im_addr holds at word 4 (fetch_pc 0x3010).
  - Head stays 0x3000.
  - Release → heads 0x3000…0x3014 with no gap or duplicate.
- DELAY_SLOT=1: head is a jump at 0x3008 with 0x300C and 0x3010 queued, jump_addr32=0x3040 → next head 0x300C, then 0x3040; 0x3010 never appears.
- DELAY_SLOT=0: same stimulus → next cycle valid=0, then head 0x3040, 0x3044.
- Address error: jump to 0x3042 → that entry has PC=0x3042, Instr=0, exc_adel=1; next entry PC=0x3046, exc_adel=1. Fetch from 0x4000 with IM_WORDS=1024 → exc_adel=1.
- Priority and ignore: branch and jump high together → jump target taken. Branch high while Stall=1 → no flush, head unchanged.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue; the head entry is the IF/ID register.
// Redirects from ID flush younger entries, optionally keeping the branch delay slot.
module fetch_queue_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 1024,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DELAY_SLOT = 1,
    localparam int unsigned AW = $clog2(IM_WORDS),
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          branch,
    input  logic [31:0]   branch_addr32,
    input  logic          jump,
    input  logic [31:0]   jump_addr32,
    input  logic          Stall,
    output logic [AW-1:0] im_addr,
    input  logic [31:0]   im_instr,
    output logic          valid,
    output logic [31:0]   Instr,
    output logic [31:0]   PC,
    output logic [31:0]   PC_4,
    output logic          exc_adel,
    output logic [CW-1:0] count
);

    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic          err_mem_q   [DEPTH];
    logic          err_mem_d   [DEPTH];

    logic          fetch_err;
    logic          full;
    logic          pop;
    logic          push;
    logic          redirect;
    logic          keep_slot;
    logic          push_block;
    logic [31:0]   target;
    logic [CW-1:0] wr_sum;
    logic [PW-1:0] wr_idx;

    assign im_addr   = AW'((fetch_pc_q - IM_BASE) >> 2);
    assign fetch_err = (fetch_pc_q[1:0] != 2'b00) | (fetch_pc_q < IM_BASE)
                     | ({1'b0, fetch_pc_q} >= IM_END);

    assign valid     = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = valid & ~Stall;
    assign redirect  = (jump | branch) & pop;
    assign target    = jump ? jump_addr32 : branch_addr32;

    // With a delay slot already queued, fetch_pc is past it, so this cycle's fetch is stale.
    assign keep_slot  = (DELAY_SLOT != 0) && (count_q >= CW'(2));
    assign push_block = redirect & ((DELAY_SLOT == 0) | (count_q > CW'(1)));
    assign push       = ~push_block & (~full | pop);

    // Write slot is rd_ptr + count; when full with a pop it lands on the head being popped.
    assign wr_sum = CW'(rd_ptr_q) + count_q;
    assign wr_idx = wr_sum[PW-1:0];

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        err_mem_d   = err_mem_q;
        if (push) begin
            pc_mem_d[wr_idx]    = fetch_pc_q;
            instr_mem_d[wr_idx] = fetch_err ? '0 : im_instr;
            err_mem_d[wr_idx]   = fetch_err;
        end
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (redirect) begin
            count_d = (keep_slot ? CW'(1) : '0) + CW'(push);
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (redirect) begin
            fetch_pc_d = target;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                err_mem_q[i]   <= 1'b0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            err_mem_q   <= err_mem_d;
        end
    end

    assign count    = count_q;
    assign Instr    = valid ? instr_mem_q[rd_ptr_q] : '0;
    assign PC       = valid ? pc_mem_q[rd_ptr_q] : '0;
    assign PC_4     = valid ? pc_mem_q[rd_ptr_q] + 32'd4 : '0;
    assign exc_adel = valid & err_mem_q[rd_ptr_q];

endmodule
